// File: rtl/onewire_pkg.sv
// Shared constants and FSM state type for the 1-Wire CRC-8 (Dallas/Maxim, reflected 0x8C) logic.
// Used by both the receive-side checker and any transmit-side CRC generator.
package onewire_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h8C;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/onewire_crc8_byte.sv
// Combinational one-byte step of the reflected Dallas/Maxim CRC-8 (x^8+x^5+x^4+1).
// Bits are consumed LSB first, matching 1-Wire bit order.
module onewire_crc8_byte
  import onewire_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  // NOTE: blocking assignments here are intentional; each loop pass reads the
  // value produced by the previous pass within the same evaluation.
  always_comb begin
    crc_next = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC8_POLY) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/onewire_crc8_check.sv
// Receive-side CRC-8 residue and frame-length checker for the 1-Wire byte stream.
// Optional feature: define ONEWIRE_CRC_ZERO_REJECT_EN to fail all-zero frames (stuck-low bus).
module onewire_crc8_check
  import onewire_pkg::*;
#(
  parameter  int MAX_BYTES = 9,
  localparam int CNT_W     = $clog2(MAX_BYTES + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             done,
  output logic             crc_ok,
  output logic             len_err,
  output logic [7:0]       crc_out,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BYTES + 1);

  state_e           state;
  logic             xfer;
  logic [7:0]       crc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             len_bad;
  logic             verdict_ok;

  assign in_ready = ~rst & (state != ST_REPORT);
  assign done     = (state == ST_REPORT);
  // A byte offered alongside abort is dropped, even when it carries in_last.
  assign xfer     = in_valid & in_ready & ~abort;

  onewire_crc8_byte u_crc8_byte (
    .crc      (crc_out),
    .data     (in_data),
    .crc_next (crc_upd)
  );

`ifdef ONEWIRE_CRC_ZERO_REJECT_EN
  logic all_zero;
  logic zero_upd;

  assign zero_upd = (in_data == 8'h00) & ((state == ST_IDLE) | all_zero);
`endif

  // Verdict is computed from the post-transfer counter and CRC so that it
  // appears in the REPORT cycle together with the final crc_out/byte_cnt.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_upd = byte_cnt;
    if (state == ST_IDLE) begin
      cnt_upd = CNT_W'(1);
    end else if (byte_cnt != CNT_SAT) begin
      cnt_upd = byte_cnt + CNT_W'(1);
    end
    len_bad    = (cnt_upd < CNT_MIN) | (cnt_upd > CNT_MAX);
    verdict_ok = (crc_upd == 8'h00) & ~len_bad;
`ifdef ONEWIRE_CRC_ZERO_REJECT_EN
    verdict_ok = verdict_ok & ~zero_upd;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      crc_out  <= CRC8_INIT;
      byte_cnt <= '0;
      crc_ok   <= 1'b0;
      len_err  <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      crc_out  <= CRC8_INIT;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (xfer) begin
            crc_out  <= crc_upd;
            byte_cnt <= cnt_upd;
            if (in_last) begin
              state   <= ST_REPORT;
              crc_ok  <= verdict_ok;
              len_err <= len_bad;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_REPORT: begin
          state    <= ST_IDLE;
          crc_out  <= CRC8_INIT;
          byte_cnt <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          crc_out  <= CRC8_INIT;
          byte_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ONEWIRE_CRC_ZERO_REJECT_EN
  always_ff @(posedge clk) begin
    if (rst || abort || (state == ST_REPORT)) begin
      all_zero <= 1'b1;
    end else if (xfer) begin
      all_zero <= zero_upd;
    end
  end
`endif

endmodule

// File: tb/tb_onewire_crc8_check.sv
// Scoreboard bench for onewire_crc8_check: driver pushes expected verdicts, monitor checks each done.
// Expectations follow ONEWIRE_CRC_ZERO_REJECT_EN when the bench is built with it.
module tb_onewire_crc8_check;

  localparam int MAX_BYTES = 9;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             done;
  logic             crc_ok;
  logic             len_err;
  logic [7:0]       crc_out;
  logic [CNT_W-1:0] byte_cnt;

  typedef struct {
    logic             ok;
    logic             len;
    logic [CNT_W-1:0] cnt;
    bit               chk_crc;
    logic [7:0]       crc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_done  = 0;
  int         stalls  = 0;
  logic       last_xfer_prev = 1'b0;
  logic [7:0] frame[$];
  logic [7:0] rom[$];
  int         done_ref;

  always #5 clk = ~clk;

  onewire_crc8_check #(.MAX_BYTES(MAX_BYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .done     (done),
    .crc_ok   (crc_ok),
    .len_err  (len_err),
    .crc_out  (crc_out),
    .byte_cnt (byte_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic ok, input logic len, input int cnt,
                                  input bit chk_crc, input logic [7:0] crc);
    exp_t e;
    e.ok      = ok;
    e.len     = len;
    e.cnt     = CNT_W'(cnt);
    e.chk_crc = chk_crc;
    e.crc     = crc;
    return e;
  endfunction

  // Monitor: every done must follow an in_last transfer by one cycle and match the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (done || last_xfer_prev) check("done_latency", done, last_xfer_prev);
      if (done) begin
        n_done++;
        check("ready_low_in_report", in_ready, 0);
        check("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("crc_ok", crc_ok, mon_e.ok);
          check("len_err", len_err, mon_e.len);
          check("byte_cnt", byte_cnt, mon_e.cnt);
          if (mon_e.chk_crc) check("crc_out", crc_out, mon_e.crc);
        end
      end
    end
    last_xfer_prev = in_valid & in_ready & in_last & ~abort & ~rst;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
      waitc++;
      if (waitc > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: in_ready low for %0d cycles, expected at most 1", waitc);
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b[$], input exp_t e, input bit hold);
    for (int i = 0; i < b.size(); i++) begin
      if (i == b.size() - 1) sb_q.push_back(e);
      send_byte(b[i], (i == b.size() - 1));
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};

    // Reset state, sampled while rst is still asserted.
    @(negedge clk);
    check("ready_in_reset", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_len_err", len_err, 0);
    check("rst_crc_out", crc_out, 8'h00);
    check("rst_byte_cnt", byte_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    idle(1);

    // Good ROM frame, then values held/cleared in IDLE.
    send_frame(rom, mk_exp(1, 0, 8, 1, 8'h00), 0);
    idle(2);
    @(negedge clk);
    check("hold_crc_ok", crc_ok, 1);
    check("idle_crc_out", crc_out, 8'h00);
    check("idle_byte_cnt", byte_cnt, 0);
    idle(1);

    // Corrupted CRC byte.
    frame = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA3};
    send_frame(frame, mk_exp(0, 0, 8, 1, 8'h5E), 0);
    idle(2);

    // All-zero frame.
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef ONEWIRE_CRC_ZERO_REJECT_EN
    send_frame(frame, mk_exp(0, 0, 8, 1, 8'h00), 0);
`else
    send_frame(frame, mk_exp(1, 0, 8, 1, 8'h00), 0);
`endif
    idle(2);

    // Shortest legal frame: data 01, CRC 5E.
    frame = '{8'h01, 8'h5E};
    send_frame(frame, mk_exp(1, 0, 2, 1, 8'h00), 0);
    idle(2);

    // Longest legal frame: ROM frame plus CRC byte 00.
    frame = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2, 8'h00};
    send_frame(frame, mk_exp(1, 0, 9, 1, 8'h00), 0);
    idle(2);

    // Ten bytes: zero residue but too long.
    frame = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2, 8'h00, 8'h00};
    send_frame(frame, mk_exp(0, 1, 10, 1, 8'h00), 0);
    idle(2);

    // Eleven bytes: counter saturates at MAX_BYTES+1.
    frame = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2, 8'h00, 8'h00, 8'h00};
    send_frame(frame, mk_exp(0, 1, 10, 1, 8'h00), 0);
    idle(2);

    // Lone CRC byte.
    frame = '{8'hA2};
    send_frame(frame, mk_exp(0, 1, 1, 0, 8'h00), 0);
    idle(2);

    // Abort after four bytes, with an in_last byte offered during abort.
    done_ref = n_done;
    for (int i = 0; i < 4; i++) send_byte(rom[i], 1'b0);
    @(negedge clk);
    check("pre_abort_cnt", byte_cnt, 4);
    abort = 1'b1; in_data = 8'hA2; in_last = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("abort_hold_crc_ok", crc_ok, 0);
    check("abort_hold_len_err", len_err, 1);
    check("abort_byte_cnt", byte_cnt, 0);
    check("abort_crc_out", crc_out, 8'h00);
    idle(1);
    send_frame(rom, mk_exp(1, 0, 8, 1, 8'h00), 0);
    idle(3);
    check("abort_done_count", n_done - done_ref, 1);

    // Back-to-back frames with in_valid held high.
    done_ref = n_done;
    stalls   = 0;
    send_frame(rom, mk_exp(1, 0, 8, 1, 8'h00), 1);
    send_frame(rom, mk_exp(1, 0, 8, 1, 8'h00), 0);
    idle(3);
    check("b2b_stall_cycles", stalls, 1);
    check("b2b_done_count", n_done - done_ref, 2);

    // Reset mid-frame clears the verdict and discards the partial frame.
    done_ref = n_done;
    for (int i = 0; i < 3; i++) send_byte(rom[i], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_crc_ok", crc_ok, 0);
    check("rst_mid_len_err", len_err, 0);
    check("rst_mid_byte_cnt", byte_cnt, 0);
    idle(1);
    frame = '{8'h01, 8'h5E};
    send_frame(frame, mk_exp(1, 0, 2, 1, 8'h00), 0);
    idle(3);
    check("rst_mid_done_count", n_done - done_ref, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
